// File: rtl/alu_md_unit.sv
// alu_md_unit: execute-stage ALU with an iterative multiply/divide unit.
//
// The combinational op set (add/sub/logic/compare/lui/shifts) produces alu_out
// in the same cycle. MULT/MULTU/DIV/DIVU run for exactly WIDTH cycles on a
// shared 2*WIDTH accumulator and then write HI/LO. MFHI/MFLO read HI/LO.
// MTHI/MTLO write HI/LO. A pipeline stall is raised while an MD/MT op waits
// for the unit.
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   alu_a      operand A (rs), shift amount in alu_a[SHW-1:0]
//   alu_b      operand B (rt/imm)
//   alu_op     5-bit operation code
//   alu_valid  op is real this cycle (gates MD/MT ops only)
//   alu_out    combinational result
//   alu_stall  hold EX this cycle
//   md_busy    multiply/divide in progress
//   md_done    one-cycle pulse after HI/LO receive a result
//   hi, lo     HI/LO registers
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | unit free; accepts MD ops and MTHI/MTLO
// S_BUSY | iterating; cnt_q counts down WIDTH..1, result written at 1
module alu_md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] alu_a,
  input  logic [WIDTH-1:0] alu_b,
  input  logic [4:0]       alu_op,
  input  logic             alu_valid,
  output logic [WIDTH-1:0] alu_out,
  output logic             alu_stall,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = SHW + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  localparam logic [4:0] OP_ZERO  = 5'd0;
  localparam logic [4:0] OP_ADD   = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_AND   = 5'd3;
  localparam logic [4:0] OP_OR    = 5'd4;
  localparam logic [4:0] OP_XOR   = 5'd5;
  localparam logic [4:0] OP_NOR   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8;
  localparam logic [4:0] OP_LUI   = 5'd9;
  localparam logic [4:0] OP_SLL   = 5'd10;
  localparam logic [4:0] OP_SRA   = 5'd11;
  localparam logic [4:0] OP_SRL   = 5'd12;
  localparam logic [4:0] OP_MULT  = 5'd13;
  localparam logic [4:0] OP_DIV   = 5'd15;
  localparam logic [4:0] OP_DIVU  = 5'd16;
  localparam logic [4:0] OP_MFHI  = 5'd17;
  localparam logic [4:0] OP_MFLO  = 5'd18;
  localparam logic [4:0] OP_MTHI  = 5'd19;
  localparam logic [4:0] OP_MTLO  = 5'd20;

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opb_q;
  logic                 is_div_q;
  logic                 neg_q;
  logic                 negr_q;
  logic                 done_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;

  logic [SHW-1:0]       shamt;
  logic                 is_md_op;
  logic                 is_mdt_op;
  logic                 md_start;
  logic                 op_signed;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_step;
  logic [WIDTH:0]       div_shift;
  logic                 div_ge;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   div_step;
  logic [2*WIDTH-1:0]   acc_d;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH-1:0]     hi_d;
  logic [WIDTH-1:0]     lo_d;

  assign shamt     = alu_a[SHW-1:0];
  assign is_md_op  = (alu_op >= 5'd13) && (alu_op <= 5'd16);
  assign is_mdt_op = (alu_op >= 5'd13) && (alu_op <= 5'd20);
  assign md_start  = alu_valid && (state_q == S_IDLE) && is_md_op;

  assign md_busy   = (state_q == S_BUSY);
  assign md_done   = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign alu_stall = alu_valid && md_busy && is_mdt_op;

  always_comb begin
    alu_out = '0;
    case (alu_op)
      OP_ZERO: alu_out = '0;
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_AND:  alu_out = alu_a & alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      OP_XOR:  alu_out = alu_a ^ alu_b;
      OP_NOR:  alu_out = ~(alu_a | alu_b);
      OP_SLTU: alu_out = {{(WIDTH-1){1'b0}}, (alu_a < alu_b)};
      OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      OP_LUI:  alu_out = {alu_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLL:  alu_out = alu_b << shamt;
      OP_SRA:  alu_out = $signed(alu_b) >>> shamt;
      OP_SRL:  alu_out = alu_b >> shamt;
      OP_MFHI: alu_out = hi_q;
      OP_MFLO: alu_out = lo_q;
      default: alu_out = '0;
    endcase
  end

  // Signed ops iterate on magnitudes; the sign flags are applied on the last step.
  assign op_signed = (alu_op == OP_MULT) || (alu_op == OP_DIV);
  assign a_neg     = op_signed && alu_a[WIDTH-1];
  assign b_neg     = op_signed && alu_b[WIDTH-1];
  assign a_mag     = a_neg ? -alu_a : alu_a;
  assign b_mag     = b_neg ? -alu_b : alu_b;

  always_comb begin
    // Shift-add: multiplier sits in the low half and is consumed from bit 0.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_step = {mul_sum, acc_q[WIDTH-1:1]};
    // Restoring divide: {remainder, quotient} shifts left, quotient bits enter at 0.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opb_q) : div_shift[WIDTH-1:0];
    div_step  = {div_rem, acc_q[WIDTH-2:0], div_ge};
    acc_d     = is_div_q ? div_step : mul_step;

    prod_fix = neg_q  ? -mul_step : mul_step;
    quo_fix  = neg_q  ? -div_step[WIDTH-1:0] : div_step[WIDTH-1:0];
    rem_fix  = negr_q ? -div_rem : div_rem;
    hi_d     = prod_fix[2*WIDTH-1:WIDTH];
    lo_d     = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      // Divide by zero leaves |dividend| in the remainder, so HI restores the dividend.
      hi_d = rem_fix;
      lo_d = (opb_q == '0) ? '1 : quo_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      negr_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (md_start) begin
            state_q  <= S_BUSY;
            cnt_q    <= CNT_LOAD;
            acc_q    <= {{WIDTH{1'b0}}, a_mag};
            opb_q    <= b_mag;
            is_div_q <= (alu_op == OP_DIV) || (alu_op == OP_DIVU);
            neg_q    <= a_neg ^ b_neg;
            negr_q   <= a_neg;
          end else if (alu_valid && (alu_op == OP_MTHI)) begin
            hi_q <= alu_a;
          end else if (alu_valid && (alu_op == OP_MTLO)) begin
            lo_q <= alu_a;
          end
        end
        S_BUSY: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
          end else begin
            cnt_q <= cnt_q - CNT_LAST;
            acc_q <= acc_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_md_unit.sv
module tb_alu_md_unit;

  logic        clk;
  logic        rst;
  logic [31:0] a32, b32, out32, hi32, lo32;
  logic [4:0]  op32;
  logic        v32, stall32, busy32, done32;
  logic [15:0] a16, b16, out16, hi16, lo16;
  logic [4:0]  op16;
  logic        v16, stall16, busy16, done16;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb_hi[$];
  logic [31:0] sb_lo[$];
  string       sb_name[$];
  logic [15:0] sb16_hi[$];
  logic [15:0] sb16_lo[$];
  int busy_cnt32 = 0;
  int busy_cnt16 = 0;

  alu_md_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .alu_a(a32), .alu_b(b32), .alu_op(op32),
    .alu_valid(v32), .alu_out(out32), .alu_stall(stall32),
    .md_busy(busy32), .md_done(done32), .hi(hi32), .lo(lo32)
  );

  alu_md_unit #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .alu_a(a16), .alu_b(b16), .alu_op(op16),
    .alu_valid(v16), .alu_out(out16), .alu_stall(stall16),
    .md_busy(busy16), .md_done(done16), .hi(hi16), .lo(lo16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout waiting for DUT", name);
  endtask

  // Monitor: pops the expected HI/LO whenever the DUT pulses md_done.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt32 = 0;
    end else begin
      if (done32 === 1'b1) begin
        if (sb_hi.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL md_done32 unexpected: got done=1 expected no result pending");
        end else begin
          string nm;
          logic [31:0] eh, el;
          nm = sb_name.pop_front();
          eh = sb_hi.pop_front();
          el = sb_lo.pop_front();
          chk({nm, " hi"}, 64'(hi32), 64'(eh));
          chk({nm, " lo"}, 64'(lo32), 64'(el));
          chk({nm, " busy cycles"}, 64'(busy_cnt32), 64'd32);
        end
        busy_cnt32 = 0;
      end
      if (busy32 === 1'b1) busy_cnt32++;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      busy_cnt16 = 0;
    end else begin
      if (done16 === 1'b1) begin
        if (sb16_hi.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL md_done16 unexpected: got done=1 expected no result pending");
        end else begin
          logic [15:0] eh, el;
          eh = sb16_hi.pop_front();
          el = sb16_lo.pop_front();
          chk("w16 multu hi", 64'(hi16), 64'(eh));
          chk("w16 multu lo", 64'(lo16), 64'(el));
          chk("w16 busy cycles", 64'(busy_cnt16), 64'd16);
        end
        busy_cnt16 = 0;
      end
      if (busy16 === 1'b1) busy_cnt16++;
    end
  end

  task automatic wait_idle32();
    bit ok = (busy32 === 1'b0);
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (busy32 === 1'b0) ok = 1;
    end
    if (!ok) timeout_fail("wait idle32");
  endtask

  task automatic wait_done32(input string name);
    bit seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (done32 === 1'b1) seen = 1;
    end
    if (!seen) timeout_fail({name, " done"});
  endtask

  task automatic comb32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    op32 = op; a32 = a; b32 = b; v32 = 1'b1;
    #1;
    chk(name, 64'(out32), 64'(exp));
    chk({name, " stall"}, 64'(stall32), 64'd0);
    v32 = 1'b0;
    @(negedge clk);
  endtask

  // Issues an MD op while idle, queues its expected HI/LO, returns just after acceptance.
  task automatic md32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] eh, input logic [31:0] el, input string name);
    wait_idle32();
    op32 = op; a32 = a; b32 = b; v32 = 1'b1;
    #1;
    chk({name, " alu_out"}, 64'(out32), 64'd0);
    sb_hi.push_back(eh);
    sb_lo.push_back(el);
    sb_name.push_back(name);
    @(posedge clk);
    #1;
    v32 = 1'b0;
    op32 = 5'd0;
  endtask

  initial begin
    int  stall_cnt;
    bit  released;
    bit  saw_done;
    bit  seen16;

    rst = 1'b1;
    a32 = '0; b32 = '0; op32 = '0; v32 = 1'b0;
    a16 = '0; b16 = '0; op16 = '0; v16 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset hi", 64'(hi32), 64'd0);
    chk("reset lo", 64'(lo32), 64'd0);
    chk("reset busy", 64'(busy32), 64'd0);
    chk("reset done", 64'(done32), 64'd0);
    chk("reset w16 busy", 64'(busy16), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    comb32(5'd1,  32'd5, 32'd7, 32'd12, "add");
    comb32(5'd2,  32'd5, 32'd7, 32'hFFFFFFFE, "sub");
    comb32(5'd7,  32'd5, 32'd7, 32'd1, "sltu 5<7");
    comb32(5'd8,  32'hFFFFFFFF, 32'd1, 32'd1, "slt -1<1");
    comb32(5'd7,  32'hFFFFFFFF, 32'd1, 32'd0, "sltu ffffffff<1");
    comb32(5'd11, 32'd4, 32'h80000000, 32'hF8000000, "sra");
    comb32(5'd12, 32'd4, 32'h80000000, 32'h08000000, "srl");
    comb32(5'd9,  32'd0, 32'h00001234, 32'h12340000, "lui");
    comb32(5'd10, 32'd5, 32'd7, 32'h000000E0, "sll");
    comb32(5'd3,  32'd5, 32'd7, 32'd5, "and");
    comb32(5'd4,  32'd5, 32'd7, 32'd7, "or");
    comb32(5'd5,  32'd5, 32'd7, 32'd2, "xor");
    comb32(5'd6,  32'd5, 32'd7, 32'hFFFFFFF8, "nor");
    comb32(5'd0,  32'd5, 32'd7, 32'd0, "op0");
    comb32(5'd25, 32'd5, 32'd7, 32'd0, "unused op25");

    md32(5'd13, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult -3*5");
    wait_done32("mult -3*5");
    comb32(5'd18, 32'd0, 32'd0, 32'hFFFFFFF1, "mflo in done cycle");
    chk("single done pulse", 64'(done32), 64'd0);
    comb32(5'd17, 32'd0, 32'd0, 32'hFFFFFFFF, "mfhi after mult");

    md32(5'd14, 32'hFFFFFFFD, 32'd5, 32'd4, 32'hFFFFFFF1, "multu");
    wait_done32("multu");
    md32(5'd16, 32'd100, 32'd7, 32'd2, 32'd14, "divu 100/7");
    wait_done32("divu 100/7");
    md32(5'd15, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");
    wait_done32("div -7/2");
    md32(5'd15, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, "div 5/0");
    wait_done32("div 5/0");
    md32(5'd15, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, "div min/-1");
    wait_done32("div min/-1");

    // MFLO held from the cycle after MULT acceptance until the stall drops.
    wait_idle32();
    op32 = 5'd13; a32 = 32'd3; b32 = 32'd4; v32 = 1'b1;
    sb_hi.push_back(32'd0);
    sb_lo.push_back(32'd12);
    sb_name.push_back("mult 3*4 stalled mflo");
    @(posedge clk);
    #1;
    op32 = 5'd18;
    stall_cnt = 0;
    released = 0;
    for (int k = 0; k < 100 && !released; k++) begin
      @(negedge clk);
      if (stall32 === 1'b1) stall_cnt++;
      else released = 1;
    end
    if (!released) timeout_fail("stall release");
    chk("stall cycles", 64'(stall_cnt), 64'd32);
    chk("done at stall release", 64'(done32), 64'd1);
    chk("mflo at stall release", 64'(out32), 64'd12);
    v32 = 1'b0;
    op32 = 5'd0;

    // Issued in the md_done cycle above, so this is also a back-to-back accept.
    md32(5'd14, 32'd6, 32'd7, 32'd0, 32'd42, "multu 6*7");
    chk("b2b accept busy", 64'(busy32), 64'd1);
    repeat (5) @(negedge clk);
    op32 = 5'd1; a32 = 32'd5; b32 = 32'd7; v32 = 1'b1;
    #1;
    chk("add mid-busy", 64'(out32), 64'd12);
    chk("add mid-busy stall", 64'(stall32), 64'd0);
    chk("add mid-busy busy", 64'(busy32), 64'd1);
    v32 = 1'b0;
    op32 = 5'd0;
    wait_done32("multu 6*7");
    md32(5'd16, 32'd100, 32'd7, 32'd2, 32'd14, "divu b2b");
    chk("b2b accept busy 2", 64'(busy32), 64'd1);
    wait_done32("divu b2b");

    // Abort with reset in busy cycle 10.
    @(negedge clk);
    op32 = 5'd13; a32 = 32'd3; b32 = 32'd4; v32 = 1'b1;
    @(posedge clk);
    #1;
    v32 = 1'b0;
    op32 = 5'd0;
    repeat (10) @(negedge clk);
    chk("busy before abort", 64'(busy32), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", 64'(busy32), 64'd0);
    chk("abort hi", 64'(hi32), 64'd0);
    chk("abort lo", 64'(lo32), 64'd0);
    rst = 1'b0;
    saw_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done32 === 1'b1) saw_done = 1;
    end
    chk("no done after abort", 64'(saw_done), 64'd0);

    op32 = 5'd19; a32 = 32'h0000CAFE; v32 = 1'b1;
    @(negedge clk);
    chk("mthi", 64'(hi32), 64'h0000CAFE);
    op32 = 5'd20; a32 = 32'h0000BEEF;
    @(negedge clk);
    chk("mtlo", 64'(lo32), 64'h0000BEEF);
    op32 = 5'd19; a32 = 32'd1; v32 = 1'b0;
    @(negedge clk);
    chk("mthi without valid", 64'(hi32), 64'h0000CAFE);
    comb32(5'd17, 32'd0, 32'd0, 32'h0000CAFE, "mfhi after mthi");

    op16 = 5'd14; a16 = 16'hFFFF; b16 = 16'hFFFF; v16 = 1'b1;
    sb16_hi.push_back(16'hFFFE);
    sb16_lo.push_back(16'h0001);
    @(posedge clk);
    #1;
    v16 = 1'b0;
    op16 = 5'd0;
    seen16 = 0;
    for (int k = 0; k < 100 && !seen16; k++) begin
      @(negedge clk);
      if (done16 === 1'b1) seen16 = 1;
    end
    if (!seen16) timeout_fail("w16 multu done");
    op16 = 5'd9; b16 = 16'h00AB;
    #1;
    chk("w16 lui", 64'(out16), 64'h000000000000AB00);

    repeat (3) @(negedge clk);
    chk("scoreboard32 drained", 64'(sb_hi.size()), 64'd0);
    chk("scoreboard16 drained", 64'(sb16_hi.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_md_unit.md
Name: alu_md_unit

Overview:
- Parametrised next-generation execute-stage ALU for the MIPS core.
- Keeps the single-cycle combinational op set: add, sub, logic, compare, lui and variable shifts.
- Adds an iterative multiply/divide unit with HI/LO registers, a start/busy/done handshake and a pipeline stall output.
- Sits in EX, fed by the decoder's op code and the forwarded operands.

Parameters:
- WIDTH, 32, datapath width. Must be even and ≥ 8.
- SHW, $clog2(WIDTH), shift-amount width. Derived; not overridable.

Ports:
- clk  input  1  clock. All state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- alu_a  input  WIDTH  operand A (rs). Shift amount is alu_a[SHW-1:0].
- alu_b  input  WIDTH  operand B (rt/imm).
- alu_op  input  5  operation code (see Behaviour).
- alu_valid  input  1  op is real this cycle. MD/MT ops only act when it is high.
- alu_out  output  WIDTH  combinational result.
- alu_stall  output  1  pipeline must hold EX this cycle.
- md_busy  output  1  multiply/divide in progress.
- md_done  output  1  one-cycle pulse when HI/LO receive a result.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset:
  - hi=0, lo=0, md_busy=0, md_done=0, internal counter=0.
  - rst during an operation aborts it. HI/LO are cleared and no md_done is produced.
- Combinational ops: alu_out is valid in the same cycle, and alu_valid is ignored.
  - 0: 0
  - 1: a+b (wrap, no overflow flag)
  - 2: a−b
  - 3: a&b
  - 4: a|b
  - 5: a^b
  - 6: ~(a|b)
  - 7: unsigned a<b (result 1/0, zero-extended)
  - 8: signed a<b
  - 9: {b[WIDTH/2-1:0], WIDTH/2 zeros}
  - 10: b<<a[SHW-1:0]
  - 11: arithmetic b>>>a[SHW-1:0]
  - 12: logical b>>a[SHW-1:0]
- MD ops: 13 MULT, 14 MULTU, 15 DIV, 16 DIVU.
  - Accepted at edge E0 when alu_valid=1 and md_busy=0. Operands are latched at E0.
  - md_busy=1 from after E0 through edge E_WIDTH, i.e. exactly WIDTH busy cycles.
  - Multiply uses iterative shift-add, one bit per cycle. Divide uses restoring division, one bit per cycle.
  - Signed variants operate on magnitudes and fix signs at the end; the fix-up is inside the WIDTH cycles.
  - At E_WIDTH: HI/LO are written, md_busy falls, and md_done=1 for the following cycle only.
  - MULT/MULTU: {HI,LO} = full 2·WIDTH product.
  - DIV/DIVU: LO = quotient, HI = remainder. Signed quotient truncates toward zero; remainder takes the sign of the dividend.
  - Divide by zero: LO = all ones, HI = dividend, with normal latency and no exception.
  - DIV of MIN by −1: LO = MIN, HI = 0.
  - alu_out for MD ops = 0.
- HI/LO access: 17 MFHI and 18 MFLO give alu_out = hi / lo.
- HI/LO writes: 19 MTHI and 20 MTLO write alu_a into hi / lo at the edge, when alu_valid=1 and md_busy=0.
- Unused ops 21–31: alu_out=0, no state change.
- alu_stall = alu_valid & md_busy & (op in 13..20).
  - A stalled op has no effect; the caller holds the same op until the stall drops.
  - MFHI/MFLO issued in the cycle md_done=1 reads the new value and does not stall.
  - Combinational ops never stall and proceed while md_busy.
- An MD op issued in the md_done cycle is accepted, giving back-to-back operations with no bubble.

Test Plan:
- WIDTH=32, combinational sweep.
  - a=5, b=7: op1 → 12, op2 → FFFFFFFE, op7 → 1.
  - a=FFFFFFFF, b=1: op8 → 1.
  - a=4, b=80000000: op11 → F8000000, op12 → 08000000.
  - op9 with b=1234 → 12340000.
- MULT a=FFFFFFFD (−3), b=5.
  - md_busy high exactly 32 cycles, md_done one pulse.
  - Result hi=FFFFFFFF, lo=FFFFFFF1.
  - MULTU of the same operands → hi=4, lo=FFFFFFF1.
- DIVU 100/7 → lo=14, hi=2.
- DIV −7/2 → lo=FFFFFFFD, hi=FFFFFFFF.
- DIV 5/0 → lo=FFFFFFFF, hi=5.
- DIV 80000000/FFFFFFFF → lo=80000000, hi=0.
- MFLO held with alu_valid=1 right after MULT acceptance.
  - alu_stall=1 for 32 cycles.
  - alu_stall=0 in the md_done cycle, where alu_out equals the new lo.
  - An op1 issued mid-busy returns a+b without stall.
- rst asserted at busy cycle 10 → next cycle md_busy=0, hi=lo=0, and no md_done ever appears.
- WIDTH=16 instance: MULTU FFFF·FFFF → hi=FFFE, lo=0001, after 16 busy cycles.
- WIDTH=16 instance: op9 b=00AB → AB00.
